// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester handshakes plus memory bus; slave = arbiter, master = requesters and memory
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by fetch and data requesters (data priority, fetch forced after STARVE_MAX lost contests); ports clk, rst, bus (mem_port_arbiter_if.slave)
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          pick_d;
  assign pick_d = bus.d_req & ~(bus.if_req & (starve_q == SW'(STARVE_MAX)));
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt_d   = 1'b0;
    d_gnt_d    = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.if_req | bus.d_req) begin
        state_d  = ISSUE;
        owner_d  = pick_d;
        we_d     = pick_d & bus.d_we;
        addr_d   = pick_d ? bus.d_addr : bus.if_addr;
        wdata_d  = pick_d ? bus.d_wdata : '0;
        mem_en_d = 1'b1;
        mem_we_d = pick_d & bus.d_we;
        d_gnt_d  = pick_d;
        if_gnt_d = ~pick_d;
        starve_d = ~pick_d ? '0 :
                   (bus.if_req && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
      end
      ISSUE: begin
        state_d   = we_q ? IDLE : WAIT;
        d_valid_d = we_q;
        cnt_d     = LW'(MEM_LAT - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d    = IDLE;
        if_valid_d = ~owner_q;
        d_valid_d  = owner_q;
        if_rdata_d = owner_q ? if_rdata_q : bus.mem_rdata;
        d_rdata_d  = owner_q ? bus.mem_rdata : d_rdata_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
    end
  end
  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT 1 and 3) checked each cycle against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int LAT  = g ? 3 : 1;
    localparam int SMAX = 4;
    logic rst;
    bit fin = 1'b0;
    logic [7:0] mem [256];
    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();
    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    // Model: one outstanding transaction described by grant cycle, valid cycle and its fields.
    int cyc = 0, mg = 0, mv = 0, starve = 0, pdue = 0;
    bit armed = 1'b0, have = 1'b0, mown = 1'b0, mwe = 1'b0, pend = 1'b0;
    logic [7:0] maddr, mwd, mrd, pdata;
    logic [7:0] e_ifr = 8'h0, e_dr = 8'h0;
    initial begin : model
      logic [38:0] exp_v, act_v;
      logic e_en;
      forever begin
        @(negedge clk);
        if (armed) begin
          if (have && cyc == mv && !mwe) begin
            if (mown) e_dr = mrd;
            else e_ifr = mrd;
          end
          e_en = have && cyc == mg;
          exp_v = {e_en && !mown, e_en && mown, e_en, e_en && mwe,
                   e_en ? maddr : 8'h0, (e_en && mwe) ? mwd : 8'h0,
                   have && cyc == mv && !mown, have && cyc == mv && mown,
                   e_ifr, e_dr, have && cyc >= mg && cyc < mv};
          act_v = {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                   e_en ? bus.mem_addr : 8'h0, (e_en && mwe) ? bus.mem_wdata : 8'h0,
                   bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata, bus.busy};
          checks++;
          if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cfg%0d cycle %0d outputs: got %h want %h", g, cyc, act_v, exp_v);
          end
          if (have && cyc == mv) have = 1'b0;
        end
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
        else if (bus.mem_en === 1'b1) begin
          pend = 1'b1;
          pdue = cyc + LAT;
          pdata = mem[bus.mem_addr];
        end
        if (pend && pdue == cyc) begin
          bus.mem_rdata = pdata;
          pend = 1'b0;
        end else bus.mem_rdata = 8'($urandom);
        if (rst) begin
          have = 1'b0;
          e_ifr = 8'h0;
          e_dr = 8'h0;
          starve = 0;
          pend = 1'b0;
          armed = 1'b1;
        end else if (armed && !have && (bus.if_req || bus.d_req)) begin
          mown = bus.d_req && !(bus.if_req && starve == SMAX);
          if (!mown) starve = 0;
          else if (bus.if_req && starve < SMAX) starve++;
          mwe = mown && bus.d_we;
          maddr = mown ? bus.d_addr : bus.if_addr;
          mwd = bus.d_wdata;
          mrd = mem[maddr];
          mg = cyc + 1;
          mv = mg + (mwe ? 1 : LAT + 1);
          have = 1'b1;
        end
        cyc++;
      end
    end
    task automatic step();
      @(posedge clk);
      #1;
    endtask
    task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL cfg%0d %s: got %0h want %0h", g, nm, got, want);
      end
    endtask
    initial begin : drive
      int n;
      string ord;
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 8'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h0; bus.d_wdata = 8'h0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (3) step();
      lit("reset outputs", {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we,
          bus.busy, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata}, 64'h0);
      rst = 1'b0;
      mem[8'h10] = 8'hA5;
      bus.if_req = 1'b1; bus.if_addr = 8'h10;
      step();
      lit("fetch gnt/en/we", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}, 64'b1010);
      lit("fetch mem_addr", bus.mem_addr, 64'h10);
      bus.if_req = 1'b0;
      for (int i = 0; i <= LAT; i++) begin
        lit("fetch busy", bus.busy, 64'h1);
        step();
      end
      lit("fetch valid/rdata/busy", {bus.if_valid, bus.if_rdata, bus.busy}, {54'h0, 1'b1, 8'hA5, 1'b0});
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 8'h3C;
      step();
      lit("write gnt/en/we", {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we}, 64'b1011);
      lit("write addr/data", {bus.mem_addr, bus.mem_wdata}, 64'h203C);
      bus.d_req = 1'b0;
      step();
      lit("write d_valid/busy", {bus.d_valid, bus.busy}, 64'b10);
      lit("write reached memory", mem[8'h20], 64'h3C);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
      bus.if_req = 1'b1; bus.if_addr = 8'h40;
      step();
      lit("contest d wins", {bus.d_gnt, bus.if_gnt}, 64'b10);
      bus.d_req = 1'b0;
      n = 1;
      while (!bus.if_gnt && n < 20) begin
        step();
        n++;
      end
      lit("contest fetch gnt cycle", 64'(n), 64'(LAT + 3));
      bus.if_req = 1'b0;
      n = 0;
      while (!bus.if_valid && n < 20) begin
        step();
        n++;
      end
      lit("contest fetch valid", bus.if_valid, 64'h1);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'($urandom);
      bus.if_req = 1'b1; bus.if_addr = 8'($urandom);
      ord = "";
      n = 0;
      while (ord.len() < 6 && n < 200) begin
        step();
        n++;
        if (bus.d_gnt) begin
          ord = {ord, "D"};
          bus.d_addr = 8'($urandom);
        end
        if (bus.if_gnt) begin
          ord = {ord, "F"};
          bus.if_addr = 8'($urandom);
        end
      end
      checks++;
      if (ord != "DDDDFD") begin
        failures++;
        $display("FAIL cfg%0d starvation order: got %s want DDDDFD", g, ord);
      end
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      n = 0;
      while (bus.busy && n < 50) begin
        step();
        n++;
      end
      step();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h55;
      step();
      lit("abort read gnt", bus.d_gnt, 64'h1);
      bus.d_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      lit("mid-read reset outputs", {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we,
          bus.busy, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata}, 64'h0);
      repeat (4) begin
        step();
        lit("no valid after abort", {bus.if_valid, bus.d_valid}, 64'h0);
      end
      mem[8'h66] = 8'h5A;
      bus.if_req = 1'b1; bus.if_addr = 8'h66;
      step();
      bus.if_req = 1'b0;
      repeat (LAT + 1) step();
      lit("post-reset fetch", {bus.if_valid, bus.if_rdata}, {55'h0, 1'b1, 8'h5A});
      for (int i = 0; i < 3000; i++) begin
        step();
        rst = $urandom_range(0, 299) == 0;
        if (bus.if_gnt || !bus.if_req) begin
          bus.if_req = $urandom_range(0, 2) != 0;
          bus.if_addr = 8'($urandom_range(0, 15));
        end
        if (bus.d_gnt || !bus.d_req) begin
          bus.d_req = $urandom_range(0, 2) != 0;
          bus.d_we = 1'($urandom);
          bus.d_addr = 8'($urandom_range(0, 15));
          bus.d_wdata = 8'($urandom);
        end
      end
      rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
      repeat (10) step();
      fin = 1'b1;
    end
  end
  initial begin
    for (int t = 0; t < 50000 && !(cfg[0].fin && cfg[1].fin); t++) @(posedge clk);
    checks++;
    if (!(cfg[0].fin && cfg[1].fin)) begin
      failures++;
      $display("FAIL timeout: got stimulus running, want done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
